// File: rtl/scr1_imem_router_np.sv
// Instruction memory router: steers core IMEM fetches to one of PORT_NUM ports by address
// mask/pattern, keeps up to MAX_OUTST in-order fetches in flight, optional internal error port.
module scr1_imem_router_np #(
  parameter int PORT_NUM  = 3,
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_OUTST = 2,
  parameter logic [PORT_NUM*AWIDTH-1:0] PORT_MASK    = {PORT_NUM{32'hFFFF0000}},
  parameter logic [PORT_NUM*AWIDTH-1:0] PORT_PATTERN = {32'h00020000, 32'h00010000, 32'h00000000},
  parameter bit   DEFAULT_PORT_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_ack,
  input  logic                       imem_req,
  input  logic                       imem_cmd,
  input  logic [AWIDTH-1:0]          imem_addr,
  output logic [DWIDTH-1:0]          imem_rdata,
  output logic [1:0]                 imem_resp,
  input  logic [PORT_NUM-1:0]        port_req_ack,
  output logic [PORT_NUM-1:0]        port_req,
  output logic [PORT_NUM-1:0]        port_cmd,
  output logic [PORT_NUM*AWIDTH-1:0] port_addr,
  input  logic [PORT_NUM*DWIDTH-1:0] port_rdata,
  input  logic [PORT_NUM*2-1:0]      port_resp
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = $clog2(PORT_NUM + 1);

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_RDY_OK = 2'd1;
  localparam logic [1:0] RESP_RDY_ER = 2'd2;

  localparam logic [PW-1:0] ERR_PORT = PW'(PORT_NUM);

  logic [CW-1:0]     outst_cnt;
  logic [PW-1:0]     cur_port;
  logic [PW-1:0]     tgt;
  logic [1:0]        port_head_resp;
  logic [DWIDTH-1:0] port_head_rdata;
  logic [1:0]        head_resp;
  logic              retire;
  logic              allow;
  logic              tgt_ack;
  logic              accept;

  // Descending scan so the lowest matching index among 1..PORT_NUM-1 wins.
  always_comb begin
    if (((imem_addr & PORT_MASK[0 +: AWIDTH]) == PORT_PATTERN[0 +: AWIDTH]) || DEFAULT_PORT_EN)
      tgt = '0;
    else
      tgt = ERR_PORT;
    for (int i = PORT_NUM - 1; i >= 1; i--) begin
      if ((imem_addr & PORT_MASK[i*AWIDTH +: AWIDTH]) == PORT_PATTERN[i*AWIDTH +: AWIDTH])
        tgt = PW'(i);
    end
  end

  always_comb begin
    port_head_resp  = RESP_NOTRDY;
    port_head_rdata = '0;
    tgt_ack         = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (cur_port == PW'(i)) begin
        port_head_resp  = port_resp[i*2 +: 2];
        port_head_rdata = port_rdata[i*DWIDTH +: DWIDTH];
      end
      if (tgt == PW'(i))
        tgt_ack = port_req_ack[i];
    end
  end

  always_comb begin
    head_resp = RESP_NOTRDY;
    if (outst_cnt != '0)
      head_resp = (cur_port == ERR_PORT) ? RESP_RDY_ER : port_head_resp;
  end

  assign retire = (head_resp == RESP_RDY_OK) || (head_resp == RESP_RDY_ER);

  // Same-port streaming up to the limit; a new port only once the last old entry retires.
  assign allow = (outst_cnt == '0)
              || ((tgt == cur_port) && ((outst_cnt < CW'(MAX_OUTST)) || retire))
              || ((outst_cnt == CW'(1)) && retire);

  assign accept       = !rst && imem_req && allow && tgt_ack;
  assign imem_req_ack = accept;
  assign imem_resp    = rst ? RESP_NOTRDY : head_resp;
  assign imem_rdata   = (!rst && (head_resp == RESP_RDY_OK)) ? port_head_rdata : '0;

  always_comb begin
    port_req  = '0;
    port_cmd  = '0;
    port_addr = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (tgt == PW'(i)) begin
        port_req[i]                   = !rst && imem_req && allow;
        port_cmd[i]                   = imem_cmd;
        port_addr[i*AWIDTH +: AWIDTH] = imem_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
      cur_port  <= '0;
    end else begin
      outst_cnt <= outst_cnt + CW'(accept) - CW'(retire);
      if (accept)
        cur_port <= tgt;
    end
  end

endmodule
